bcd_display_scan: RTL and testbench

- Consumer side of the four-character BCD code bus (`bcd_3`..`bcd_0`, 5-bit codes per the `BCD_*` definitions in `constants.h`).
- Latches a new character set on a load strobe and applies it only at frame boundaries, so the display never tears.
- Time-multiplexes the four characters onto a shared active-low seven-segment bus with per-digit anode enables.
- Supports an optional blink mode. Sits between the state/character logic and the board display pins.

---
 rtl/bcd_display_scan.sv | 162 ++++++++++++++++
 tb/tb_bcd_display_scan.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed seven-segment driver for the BCD character bus.
// New character sets are staged and only take effect on a frame boundary.
module bcd_display_scan #(
    parameter int unsigned SCAN_DIV     = 12500,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] bcd_0,
    input  logic [4:0] bcd_1,
    input  logic [4:0] bcd_2,
    input  logic [4:0] bcd_3,
    input  logic       blink_en,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       frame_done
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [4:0] BCD_0     = 5'd0;
    localparam logic [4:0] BCD_1     = 5'd1;
    localparam logic [4:0] BCD_2     = 5'd2;
    localparam logic [4:0] BCD_3     = 5'd3;
    localparam logic [4:0] BCD_4     = 5'd4;
    localparam logic [4:0] BCD_5     = 5'd5;
    localparam logic [4:0] BCD_6     = 5'd6;
    localparam logic [4:0] BCD_7     = 5'd7;
    localparam logic [4:0] BCD_8     = 5'd8;
    localparam logic [4:0] BCD_9     = 5'd9;
    localparam logic [4:0] BCD_A     = 5'd10;
    localparam logic [4:0] BCD_B     = 5'd11;
    localparam logic [4:0] BCD_C     = 5'd12;
    localparam logic [4:0] BCD_D     = 5'd13;
    localparam logic [4:0] BCD_E     = 5'd14;
    localparam logic [4:0] BCD_F     = 5'd15;
    localparam logic [4:0] BCD_G     = 5'd16;
    localparam logic [4:0] BCD_H     = 5'd17;
    localparam logic [4:0] BCD_L     = 5'd18;
    localparam logic [4:0] BCD_O     = 5'd19;
    localparam logic [4:0] BCD_P     = 5'd20;
    localparam logic [4:0] BCD_R     = 5'd21;
    localparam logic [4:0] BCD_U     = 5'd22;
    localparam logic [4:0] BCD_DASH  = 5'd23;
    localparam logic [4:0] BCD_BLANK = 5'd31;

    // Active-low {g,f,e,d,c,b,a}; blank and undefined codes light nothing.
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] g;
        g = 7'h7F;
        case (code)
            BCD_0, BCD_O: g = 7'h40;
            BCD_1:        g = 7'h79;
            BCD_2:        g = 7'h24;
            BCD_3:        g = 7'h30;
            BCD_4:        g = 7'h19;
            BCD_5:        g = 7'h12;
            BCD_6:        g = 7'h02;
            BCD_7:        g = 7'h78;
            BCD_8:        g = 7'h00;
            BCD_9:        g = 7'h10;
            BCD_A:        g = 7'h08;
            BCD_B:        g = 7'h03;
            BCD_C:        g = 7'h46;
            BCD_D:        g = 7'h21;
            BCD_E:        g = 7'h06;
            BCD_F:        g = 7'h0E;
            BCD_G:        g = 7'h42;
            BCD_H:        g = 7'h09;
            BCD_L:        g = 7'h47;
            BCD_P:        g = 7'h0C;
            BCD_R:        g = 7'h2F;
            BCD_U:        g = 7'h41;
            BCD_DASH:     g = 7'h3F;
            BCD_BLANK:    g = 7'h7F;
            default:      g = 7'h7F;
        endcase
        return g;
    endfunction

    logic [PW-1:0]      prescaler;
    logic [1:0]         digit;
    logic [3:0][4:0]    active;
    logic [3:0][4:0]    pending;
    logic               pend_valid;
    logic [BW-1:0]      blink_cnt;
    logic               phase;
    logic [3:0][4:0]    bcd_in;
    logic               tick;
    logic               fb;

    assign bcd_in = {bcd_3, bcd_2, bcd_1, bcd_0};
    assign tick   = (prescaler == PS_LAST);
    assign fb     = tick && (digit == 2'd3);

    // Digit-slot timebase and frame boundary pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            digit      <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= tick ? '0 : prescaler + PW'(1);
            if (tick) digit <= digit + 2'd1;
            frame_done <= fb;
        end
    end

    // Staging: a load coinciding with the boundary bypasses the pending slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= {4{BCD_BLANK}};
            pending    <= {4{BCD_BLANK}};
            pend_valid <= 1'b0;
        end else if (load && fb) begin
            active     <= bcd_in;
            pend_valid <= 1'b0;
        end else if (load) begin
            pending    <= bcd_in;
            pend_valid <= 1'b1;
        end else if (fb && pend_valid) begin
            active     <= pending;
            pend_valid <= 1'b0;
        end
    end

    // Blink phase advances once every BLINK_FRAMES frames while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (fb) begin
            if (blink_cnt == BC_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n  <= 4'hF;
            seg_n <= 7'h7F;
        end else if (blink_en && phase) begin
            an_n  <= 4'hF;
            seg_n <= 7'h7F;
        end else begin
            an_n  <= ~(4'b0001 << digit);
            seg_n <= glyph(active[digit]);
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with SCAN_DIV=4, BLINK_FRAMES=2 (16 clk per frame).
module tb_bcd_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [4:0] bcd_0, bcd_1, bcd_2, bcd_3;
    logic       blink_en;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    localparam logic [4:0] C_1 = 5'd1,  C_A = 5'd10, C_B = 5'd11, C_D = 5'd13;
    localparam logic [4:0] C_F = 5'd15, C_G = 5'd16, C_L = 5'd18, C_O = 5'd19;
    localparam logic [4:0] C_R = 5'd21;

    // Codes {bcd_3, bcd_2, bcd_1, bcd_0}; glyphs indexed by digit
    localparam logic [3:0][4:0] CODE_GOOD = {C_G, C_O, C_O, C_D};
    localparam logic [3:0][4:0] CODE_FA1L = {C_F, C_A, C_1, C_L};
    localparam logic [3:0][4:0] CODE_BORD = {C_B, C_O, C_R, C_D};
    localparam logic [3:0][6:0] G_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [3:0][6:0] G_GOOD  = {7'h42, 7'h40, 7'h40, 7'h21};
    localparam logic [3:0][6:0] G_FA1L  = {7'h0E, 7'h08, 7'h79, 7'h47};
    localparam logic [3:0][6:0] G_BORD  = {7'h03, 7'h40, 7'h2F, 7'h21};

    bcd_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_0      (bcd_0),
        .bcd_1      (bcd_1),
        .bcd_2      (bcd_2),
        .bcd_3      (bcd_3),
        .blink_en   (blink_en),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock, then compare outputs against the digit slot implied by cyc
    task automatic step_chk(input logic [3:0][6:0] g, input bit dark);
        int         idx;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        idx     = ((cyc - 1) / 4) % 4;
        exp_an  = dark ? 4'hF : ~(4'b0001 << idx);
        exp_seg = dark ? 7'h7F : g[idx];
        check("an_n", 32'(an_n), 32'(exp_an));
        check("seg_n", 32'(seg_n), 32'(exp_seg));
        check("frame_done", 32'(frame_done), (cyc % 16 == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run(input int n, input logic [3:0][6:0] g, input bit dark);
        for (int i = 0; i < n; i++) step_chk(g, dark);
    endtask

    task automatic do_load(input logic [3:0][4:0] codes, input logic [3:0][6:0] g);
        {bcd_3, bcd_2, bcd_1, bcd_0} = codes;
        load = 1'b1;
        step_chk(g, 1'b0);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; blink_en = 1'b0;
        {bcd_3, bcd_2, bcd_1, bcd_0} = '0;
        repeat (3) @(negedge clk);
        check("rst_an_n", 32'(an_n), 32'hF);
        check("rst_seg_n", 32'(seg_n), 32'h7F);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Idle scan with blanks
        run(32, G_BLANK, 1'b0);

        // Single load mid-frame takes effect only after the wrap
        run(5, G_BLANK, 1'b0);
        do_load(CODE_GOOD, G_BLANK);
        run(10, G_BLANK, 1'b0);
        run(16, G_GOOD, 1'b0);

        // Two loads in one frame: last wins
        run(1, G_GOOD, 1'b0);
        do_load(CODE_GOOD, G_GOOD);
        run(3, G_GOOD, 1'b0);
        do_load(CODE_FA1L, G_GOOD);
        run(10, G_GOOD, 1'b0);
        run(16, G_FA1L, 1'b0);

        // Load on the boundary cycle overrides a pending set
        run(2, G_FA1L, 1'b0);
        do_load(CODE_GOOD, G_FA1L);
        run(12, G_FA1L, 1'b0);
        do_load(CODE_BORD, G_FA1L);
        run(32, G_BORD, 1'b0);

        // Blink: two frames lit, two dark, repeating
        run(5, G_BORD, 1'b0);
        do_load(CODE_GOOD, G_BORD);
        run(10, G_BORD, 1'b0);
        blink_en = 1'b1;
        run(32, G_GOOD, 1'b0);
        run(32, G_GOOD, 1'b1);
        run(32, G_GOOD, 1'b0);
        run(8, G_GOOD, 1'b1);
        blink_en = 1'b0;
        run(12, G_GOOD, 1'b0);

        // Reset mid digit 2 with a pending set
        do_load(CODE_FA1L, G_GOOD);
        run(5, G_GOOD, 1'b0);
        rst = 1'b1;
        #1;
        check("async_an_n", 32'(an_n), 32'hF);
        check("async_seg_n", 32'(seg_n), 32'h7F);
        check("async_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        check("held_an_n", 32'(an_n), 32'hF);
        rst = 1'b0;
        cyc = 0;
        run(32, G_BLANK, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
